function_table_interp: RTL and testbench
========================================

Name: function_table_interp

Overview:
- Multi-channel, pipelined successor to the single-channel function table.
- Evaluates a nonlinear activation (tanh / sigmoid / identity) on CHANNELS signed inputs.
- Uses a coarse elaboration-time LUT plus linear interpolation, so the result is smoother than a direct per-code table and needs far less storage.
- Sits between the reservoir accumulator and the readout. One shared interpolation lane serves all channels in time; valid/ready handshakes sit on both sides.

Parameters:
- WIDTH_X, 10, input sample width (signed two's complement).
- WIDTH_Y, 8, output sample width (signed two's complement).
- SEG_BITS, 5, log2 of segment count. The LUT holds 2^SEG_BITS+1 nodes. FRAC_BITS = WIDTH_X-SEG_BITS.
- CHANNELS, 4, samples per vector (>=1).
- SCALE_X, 32.0, real input value is x_real = x_int/SCALE_X.
- SCALE_Y, 1.0, node value is round(f(x_real)*SCALE_Y*(2^(WIDTH_Y-1)-1)), saturated to WIDTH_Y.
- TARGET, "tanh", one of "tanh", "sigmoid", "identity". Any other value is an elaboration error.

Ports:
- iCLK  in  1  clock
- iRST  in  1  asynchronous active-high reset
- iValid  in  1  input vector valid
- oReady  out  1  block can accept an input vector
- iData  in  CHANNELS*WIDTH_X  packed inputs, channel 0 in the LSBs
- oValid  out  1  output vector valid
- iReady  in  1  downstream accepts the output vector
- oData  out  CHANNELS*WIDTH_Y  packed results, channel 0 in the LSBs

Behaviour:
- Reset: state=IDLE, oValid=0, oReady=0 while iRST is high, oData=0. The pipeline and channel counter clear. The LUT is a constant and is not reset.
- States:
  - IDLE: oReady=1. iValid&oReady captures iData into the input register, sets ch=0 and moves to RUN.
  - RUN: issues channel ch into the lane each cycle, ch++. After issuing ch=CHANNELS-1, moves to DRAIN.
  - DRAIN: waits until the last lane result is written, then moves to DONE with oValid=1.
  - DONE: holds oValid and oData stable until iReady. oReady = iReady in DONE.
    - iValid&iReady: capture the new vector and go to RUN (back-to-back, no bubble).
    - iReady only: go to IDLE.
- Lane, 3 stages:
  - S1: u = x ^ (1<<(WIDTH_X-1)) (offset binary). idx = u[WIDTH_X-1:FRAC_BITS], frac = u[FRAC_BITS-1:0]. Read y0 = LUT[idx] and y1 = LUT[idx+1].
  - S2: d = (y1-y0)*frac, computed at full width WIDTH_Y+1+FRAC_BITS.
  - S3: y = y0 + ((d + 2^(FRAC_BITS-1)) >>> FRAC_BITS). Rounding is half-up toward +inf. Saturate y to [-(2^(WIDTH_Y-1)), 2^(WIDTH_Y-1)-1] and write it to the oData slot for that channel.
- Latency: oValid rises on the (CHANNELS+3)th rising edge after the accepting edge. This is 7 for the default CHANNELS=4.
- Throughput: one vector per CHANNELS+3 cycles when iReady is held high.
- Boundaries:
  - idx+1 never overflows, because node 2^SEG_BITS exists.
  - Max input (u = all ones) interpolates within the last segment.
  - frac=0 returns y0 exactly.
- iValid while busy (RUN/DRAIN) is ignored; oReady=0 in those states.
- oData changes only on slot writes during RUN/DRAIN. It never changes while oValid=1 and iReady=0.
- Asynchronous reset mid-operation discards the vector in flight. No partial oValid is ever produced.

Decomposition:
- Package func_table_pkg holds:
  - target encoding constants (TGT_TANH, TGT_SIGMOID, TGT_IDENTITY);
  - an elaboration function that builds a node value from index, SCALE_X, SCALE_Y and target;
  - a saturate(WIDTH_Y) function.
- Sub-module function_interp_lane holds the 3-stage S1–S3 pipeline and the LUT. Its ports are an input valid+x+channel tag and an output valid+y+tag. The top level keeps the FSM, the channel counter, and the input/output vector registers.

Test Plan (defaults, TARGET="tanh"):
- Reset then vector {0, 32, 16, -32}, iReady=1:
  - oValid on edge 7 after accept;
  - oData channels = {0, 97, 49, -97};
  - node 17 = round(tanh(1)*127) = 97; midpoint 16 interpolates to 49.
- Extremes {511, -512, 0, 0}: result {127, -127, 0, 0}. Checks saturation and last-segment indexing with no out-of-range LUT read.
- Backpressure: hold iReady=0 for 10 cycles after oValid.
  - oValid and oData stay stable.
  - oReady=0 throughout.
  - Raise iReady with iValid=1 and a new vector: accepted on the same edge, next oValid 7 edges later.
- Sweep iData over -512..511 in channel 2 (others 0):
  - matches a reference model of the interpolation formula bit-exactly;
  - monotonic non-decreasing output.
- Assert iRST two cycles into RUN:
  - oValid=0, oData=0 immediately;
  - after release, a fresh vector {0,0,0,32} returns {0,0,0,97} with no residue from the aborted vector.
- iValid pulsed during RUN is ignored: exactly one output vector is produced, and it corresponds to the first capture.

Source files
------------

// File: rtl/function_table_interp_pkg.sv
// Shared state encoding, target codes and elaboration-time helpers used to
// build the interpolation node table for function_table_interp.
package func_table_pkg;

  localparam int TGT_TANH     = 32'sd0;
  localparam int TGT_SIGMOID  = 32'sd1;
  localparam int TGT_IDENTITY = 32'sd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int saturate(input int value, input int width);
    int hi;
    int lo;
    hi = (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 32'sd1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

  function automatic int roundHalfAway(input real r);
    if (r >= 0.0) begin
      return $rtoi(r + 0.5);
    end else begin
      return -$rtoi(0.5 - r);
    end
  endfunction

  // Node idx sits at offset-binary code idx<<FRAC_BITS, i.e. x_int = that code minus the sign offset.
  function automatic int nodeValue(input int idx, input int segBits, input int widthX,
                                   input int widthY, input real scaleX, input real scaleY,
                                   input int tgt);
    int  xInt;
    real xReal;
    real fx;
    xInt  = idx * (32'sd1 <<< (widthX - segBits)) - (32'sd1 <<< (widthX - 32'sd1));
    xReal = real'(xInt) / scaleX;
    case (tgt)
      TGT_SIGMOID:  fx = 1.0 / (1.0 + $exp(-xReal));
      TGT_IDENTITY: fx = xReal;
      default:      fx = $tanh(xReal);
    endcase
    return saturate(roundHalfAway(fx * scaleY * real'((32'sd1 <<< (widthY - 32'sd1)) - 32'sd1)),
                    widthY);
  endfunction

endpackage

// File: rtl/function_table_interp_lane.sv
// Shared 3-stage interpolation lane: node lookup, slope multiply, round and
// saturate. The channel tag travels alongside each sample.
module function_interp_lane
  import func_table_pkg::*;
#(
  parameter int  WIDTH_X  = 10,
  parameter int  WIDTH_Y  = 8,
  parameter int  SEG_BITS = 5,
  parameter real SCALE_X  = 32.0,
  parameter real SCALE_Y  = 1.0,
  parameter int  TGT      = TGT_TANH,
  parameter int  TAG_W    = 2
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iValid,
  input  logic signed [WIDTH_X-1:0] iX,
  input  logic        [TAG_W-1:0]   iTag,
  output logic                      oValid,
  output logic signed [WIDTH_Y-1:0] oY,
  output logic        [TAG_W-1:0]   oTag
);

  localparam int FRAC_BITS = WIDTH_X - SEG_BITS;
  localparam int NODES     = (32'sd1 <<< SEG_BITS) + 32'sd1;
  localparam int DIFF_W    = WIDTH_Y + 1;
  localparam int PROD_W    = WIDTH_Y + 1 + FRAC_BITS;
  localparam logic [WIDTH_X-1:0]  SIGN_FLIP  = {1'b1, {(WIDTH_X-1){1'b0}}};
  localparam logic signed [31:0]  ROUND_HALF = 32'sd1 <<< (FRAC_BITS - 1);

  logic signed [WIDTH_Y-1:0] nodeLut_s [NODES];
  logic        [WIDTH_X-1:0] u_s;
  logic        [SEG_BITS:0]  idx_s;
  logic        [SEG_BITS:0]  idxNext_s;
  logic signed [DIFF_W-1:0]  diff_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [31:0]        sum_s;

  logic                      s1Valid_r;
  logic        [TAG_W-1:0]   s1Tag_r;
  logic signed [WIDTH_Y-1:0] s1Y0_r;
  logic signed [WIDTH_Y-1:0] s1Y1_r;
  logic      [FRAC_BITS-1:0] s1Frac_r;
  logic                      s2Valid_r;
  logic        [TAG_W-1:0]   s2Tag_r;
  logic signed [WIDTH_Y-1:0] s2Y0_r;
  logic signed [PROD_W-1:0]  s2Prod_r;

  for (genvar g = 0; g < NODES; g++) begin : gNode
    assign nodeLut_s[g] = WIDTH_Y'(nodeValue(g, SEG_BITS, WIDTH_X, WIDTH_Y, SCALE_X, SCALE_Y, TGT));
  end

  // Extra node at index 2^SEG_BITS keeps idx+1 in range for the top segment.
  assign u_s       = iX ^ SIGN_FLIP;
  assign idx_s     = {1'b0, u_s[WIDTH_X-1:FRAC_BITS]};
  assign idxNext_s = idx_s + {{SEG_BITS{1'b0}}, 1'b1};
  assign diff_s    = DIFF_W'(s1Y1_r) - DIFF_W'(s1Y0_r);
  assign prod_s    = PROD_W'(diff_s) * PROD_W'($signed({1'b0, s1Frac_r}));
  assign sum_s     = 32'(s2Y0_r) + ((32'(s2Prod_r) + ROUND_HALF) >>> FRAC_BITS);

  // Pipeline registers for S1 (lookup), S2 (slope product) and S3 (rounded result).
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1Valid_r <= 1'b0;
      s1Tag_r   <= '0;
      s1Y0_r    <= '0;
      s1Y1_r    <= '0;
      s1Frac_r  <= '0;
      s2Valid_r <= 1'b0;
      s2Tag_r   <= '0;
      s2Y0_r    <= '0;
      s2Prod_r  <= '0;
      oValid    <= 1'b0;
      oTag      <= '0;
      oY        <= '0;
    end else begin
      s1Valid_r <= iValid;
      s1Tag_r   <= iTag;
      s1Y0_r    <= nodeLut_s[idx_s];
      s1Y1_r    <= nodeLut_s[idxNext_s];
      s1Frac_r  <= u_s[FRAC_BITS-1:0];
      s2Valid_r <= s1Valid_r;
      s2Tag_r   <= s1Tag_r;
      s2Y0_r    <= s1Y0_r;
      s2Prod_r  <= prod_s;
      oValid    <= s2Valid_r;
      oTag      <= s2Tag_r;
      oY        <= WIDTH_Y'(saturate(sum_s, WIDTH_Y));
    end
  end

endmodule

// File: rtl/function_table_interp.sv
// Multi-channel activation block: captures a vector, streams its channels
// through one shared interpolation lane and presents the assembled result.
module function_table_interp
  import func_table_pkg::*;
#(
  parameter int    WIDTH_X  = 10,
  parameter int    WIDTH_Y  = 8,
  parameter int    SEG_BITS = 5,
  parameter int    CHANNELS = 4,
  parameter real   SCALE_X  = 32.0,
  parameter real   SCALE_Y  = 1.0,
  parameter string TARGET   = "tanh"
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iValid,
  output logic                         oReady,
  input  logic [CHANNELS*WIDTH_X-1:0]  iData,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [CHANNELS*WIDTH_Y-1:0]  oData
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TGT  = (TARGET == "tanh")     ? TGT_TANH     :
                        (TARGET == "sigmoid")  ? TGT_SIGMOID  :
                        (TARGET == "identity") ? TGT_IDENTITY : -32'sd1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  if (TGT < 0) begin : gBadTarget
    $error("function_table_interp: unsupported TARGET \"%s\"", TARGET);
  end

  state_e                      state_r;
  state_e                      nextState_s;
  logic [CH_W-1:0]             chCnt_r;
  logic [CHANNELS*WIDTH_X-1:0] inVec_r;
  logic                        accept_s;
  logic                        issue_s;
  logic signed [WIDTH_X-1:0]   laneX_s;
  logic                        laneValid_s;
  logic signed [WIDTH_Y-1:0]   laneY_s;
  logic [CH_W-1:0]             laneTag_s;

  assign laneX_s = inVec_r[chCnt_r*WIDTH_X +: WIDTH_X];
  assign oValid  = (state_r == ST_DONE);

  function_interp_lane #(
    .WIDTH_X (WIDTH_X),
    .WIDTH_Y (WIDTH_Y),
    .SEG_BITS(SEG_BITS),
    .SCALE_X (SCALE_X),
    .SCALE_Y (SCALE_Y),
    .TGT     (TGT),
    .TAG_W   (CH_W)
  ) uLane (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iValid(issue_s),
    .iX    (laneX_s),
    .iTag  (chCnt_r),
    .oValid(laneValid_s),
    .oY    (laneY_s),
    .oTag  (laneTag_s)
  );

  // Next-state, accept and issue decode; DONE passes iReady through for back-to-back vectors.
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    oReady      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        oReady = ~iRST;
        if (iValid && !iRST) begin
          accept_s    = 1'b1;
          nextState_s = ST_RUN;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue_s = 1'b1;
        if (chCnt_r == LAST_CH) begin
          nextState_s = ST_DRAIN;
        end else begin
          nextState_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (laneValid_s && (laneTag_s == LAST_CH)) begin
          nextState_s = ST_DONE;
        end else begin
          nextState_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        oReady = iReady;
        if (iReady && iValid) begin
          accept_s    = 1'b1;
          nextState_s = ST_RUN;
        end else if (iReady) begin
          nextState_s = ST_IDLE;
        end else begin
          nextState_s = ST_DONE;
        end
      end
      default: nextState_s = ST_IDLE;
    endcase
  end

  // State, channel counter, captured input vector and per-slot result writes.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r <= ST_IDLE;
      chCnt_r <= '0;
      inVec_r <= '0;
      oData   <= '0;
    end else begin
      state_r <= nextState_s;
      if (accept_s) begin
        inVec_r <= iData;
        chCnt_r <= '0;
      end else if (issue_s) begin
        chCnt_r <= chCnt_r + CH_W'(1'b1);
      end
      if (laneValid_s) begin
        oData[laneTag_s*WIDTH_Y +: WIDTH_Y] <= laneY_s;
      end
    end
  end

endmodule

// File: tb/tb_function_table_interp.sv
// Scoreboard bench for function_table_interp: directed, randomized and sweep
// vectors checked against a real-arithmetic tanh interpolation model.
module tb_function_table_interp;

  localparam int WX   = 10;
  localparam int WY   = 8;
  localparam int CH   = 4;
  localparam int FB   = 5;
  localparam int LAT  = CH + 3;
  localparam int YMAX = 127;

  logic           iCLK   = 1'b0;
  logic           iRST   = 1'b1;
  logic           iValid = 1'b0;
  logic           iReady = 1'b0;
  logic [CH*WX-1:0] iData = '0;
  logic           oReady;
  logic           oValid;
  logic [CH*WY-1:0] oData;

  function_table_interp dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iValid(iValid),
    .oReady(oReady),
    .iData (iData),
    .oValid(oValid),
    .iReady(iReady),
    .oData (oData)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [CH*WY-1:0] data;
    int               acc;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   outCount   = 0;
  bit   sweepMode  = 1'b0;
  int   sweepPrev  = -1000;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNote(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got no valid event, required one within bound (t=%0t)", name, $time);
  endtask

  function automatic int clampY(input int v);
    if (v > YMAX) return YMAX;
    if (v < -YMAX - 1) return -YMAX - 1;
    return v;
  endfunction

  // tanh sampled at integer real inputs -16..16, scaled to 127 and rounded to nearest
  function automatic int refNode(input int i);
    real s;
    s = $tanh(real'(i - 16)) * real'(YMAX);
    if (s >= 0.0) return clampY($rtoi($floor(s + 0.5)));
    else return clampY(-$rtoi($floor(-s + 0.5)));
  endfunction

  function automatic int refInterp(input int x);
    int u, seg, frac, y0, y1;
    u    = x + 512;
    seg  = u / 32;
    frac = u % 32;
    y0   = refNode(seg);
    y1   = refNode(seg + 1);
    return clampY(y0 + $rtoi($floor(real'((y1 - y0) * frac) / 32.0 + 0.5)));
  endfunction

  function automatic logic [CH*WX-1:0] packX(input int a, input int b, input int c, input int d);
    int vals[4];
    int t;
    logic [CH*WX-1:0] r;
    vals = '{a, b, c, d};
    for (int i = 0; i < CH; i++) begin
      t = vals[i];
      r[i*WX +: WX] = t[WX-1:0];
    end
    return r;
  endfunction

  function automatic logic [CH*WY-1:0] packY(input int a, input int b, input int c, input int d);
    int vals[4];
    int t;
    logic [CH*WY-1:0] r;
    vals = '{a, b, c, d};
    for (int i = 0; i < CH; i++) begin
      t = vals[i];
      r[i*WY +: WY] = t[WY-1:0];
    end
    return r;
  endfunction

  function automatic logic [CH*WY-1:0] refVec(input logic [CH*WX-1:0] v);
    logic [CH*WY-1:0] r;
    int x, y;
    for (int c = 0; c < CH; c++) begin
      x = $signed(v[c*WX +: WX]);
      y = refInterp(x);
      r[c*WY +: WY] = y[WY-1:0];
    end
    return r;
  endfunction

  task automatic sendVec(input logic [CH*WX-1:0] v, input logic [CH*WY-1:0] e);
    int n;
    n = 0;
    iData  = v;
    iValid = 1'b1;
    @(negedge iCLK);
    while (!oReady && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    if (!oReady) begin
      failNote("send_accept_timeout");
    end else begin
      sbQ.push_back('{e, cyc + 1});
    end
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
  endtask

  task automatic waitEmpty(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 500) begin
      @(negedge iCLK);
      n++;
    end
    if (sbQ.size() != 0) failNote(name);
    @(posedge iCLK);
    #1;
  endtask

  // Monitor: latency on each oValid rise, data compare on each output handshake.
  initial begin
    bit prevV;
    int y2;
    prevV = 1'b0;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        prevV = 1'b0;
      end else begin
        if (oValid && !prevV) begin
          if (sbQ.size() == 0) failNote("unexpected_output");
          else check("latency", cyc - sbQ[0].acc, LAT);
        end
        if (oValid && iReady && sbQ.size() != 0) begin
          check("out_data", oData, sbQ[0].data);
          void'(sbQ.pop_front());
          outCount++;
          if (sweepMode) begin
            y2 = $signed(oData[2*WY +: WY]);
            check("sweep_monotonic", (y2 >= sweepPrev), 1);
            sweepPrev = y2;
          end
        end
        prevV = oValid;
      end
    end
  end

  initial begin
    #2ms;
    failNote("global_watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CH*WX-1:0] v;
    logic [CH*WY-1:0] e;
    int c0;
    int n;

    repeat (2) @(negedge iCLK);
    check("reset_ovalid", oValid, 0);
    check("reset_oready", oReady, 0);
    check("reset_odata", oData, 0);
    @(posedge iCLK);
    #1;
    iRST   = 1'b0;
    iReady = 1'b1;

    sendVec(packX(0, 32, 16, -32), packY(0, 97, 49, -97));
    sendVec(packX(511, -512, 0, 0), packY(127, -127, 0, 0));
    waitEmpty("drain_directed");

    // Backpressure: result must hold while iReady is low, then a new vector rides the release edge.
    iReady = 1'b0;
    v = packX(100, -100, 7, -300);
    e = refVec(v);
    sendVec(v, e);
    n = 0;
    while (!oValid && n < 50) begin
      @(negedge iCLK);
      n++;
    end
    if (!oValid) failNote("bp_ovalid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge iCLK);
      check("bp_ovalid", oValid, 1);
      check("bp_odata", oData, e);
      check("bp_oready", oReady, 0);
    end
    @(posedge iCLK);
    #1;
    iReady = 1'b1;
    v = packX(-1, 1, -200, 200);
    sendVec(v, refVec(v));
    waitEmpty("drain_bp");

    for (int i = 0; i < 40; i++) begin
      v = packX($urandom_range(1023) - 512, $urandom_range(1023) - 512,
                $urandom_range(1023) - 512, $urandom_range(1023) - 512);
      sendVec(v, refVec(v));
    end
    waitEmpty("drain_random");

    sweepPrev = -1000;
    sweepMode = 1'b1;
    for (int x = -512; x <= 511; x++) begin
      v = packX(0, 0, x, 0);
      sendVec(v, refVec(v));
    end
    waitEmpty("drain_sweep");
    sweepMode = 1'b0;

    // Reset two cycles into RUN discards the vector and clears the result register.
    v = packX(300, -300, 45, -45);
    sendVec(v, refVec(v));
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    sbQ.delete();
    #1;
    check("rst_mid_ovalid", oValid, 0);
    check("rst_mid_odata", oData, 0);
    check("rst_mid_oready", oReady, 0);
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    sendVec(packX(0, 0, 0, 32), packY(0, 0, 0, 97));
    waitEmpty("drain_after_reset");

    c0 = outCount;
    v = packX(-512, 511, 64, -64);
    sendVec(v, refVec(v));
    @(posedge iCLK);
    #1;
    iData  = packX(1, 2, 3, 4);
    iValid = 1'b1;
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
    waitEmpty("drain_busy_pulse");
    repeat (20) @(negedge iCLK);
    check("busy_ivalid_ignored", outCount - c0, 1);
    check("final_queue_empty", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
